oe_mul_seq: RTL and testbench

OE_MUL_SEQ -- requirements
Module: oe_mul_seq

---
 rtl/oe_mul_pkg.sv | 26 ++
 rtl/oe_mul_seq_if.sv | 33 +++
 rtl/oe_tag_pipe.sv | 40 ++++
 rtl/oe_mul_seq.sv | 133 +++++++++++++
 tb/tb_oe_mul_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/oe_mul_pkg.sv
// rtl/oe_mul_pkg.sv - shared encodings for the odd/even multiply sequencer
package oe_mul_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_E = 3'd1,
        ISSUE_O = 3'd2,
        DRAIN   = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] MODE_EVEN = 2'b00;
    localparam logic [1:0] MODE_ODD  = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    localparam logic [1:0] WW_BYTE = 2'b00;
    localparam logic [1:0] WW_HALF = 2'b01;
    localparam logic [1:0] WW_WORD = 2'b10;
    localparam logic [1:0] WW_ILL  = 2'b11;

    function automatic logic req_illegal(input logic [1:0] mode, input logic [1:0] ww);
        return (mode == MODE_ILL) || (ww == WW_ILL);
    endfunction

endpackage

// File: rtl/oe_mul_seq_if.sv
// rtl/oe_mul_seq_if.sv - request, selector, multiplier and response signals of the sequencer
interface oe_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [1:0]  req_ww;
    logic [1:0]  req_mode;
    logic [63:0] sel_op1;
    logic [63:0] sel_op2;
    logic        sel_odd;
    logic [1:0]  sel_ww;
    logic        mul_issue;
    logic [63:0] mul_prod;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_even;
    logic [63:0] rsp_odd;
    logic        rsp_err;
    logic [15:0] ops_done;

    modport slave (
        input  req_valid, req_op1, req_op2, req_ww, req_mode, mul_prod, rsp_ready,
        output req_ready, sel_op1, sel_op2, sel_odd, sel_ww, mul_issue,
               rsp_valid, rsp_even, rsp_odd, rsp_err, ops_done
    );

    modport master (
        output req_valid, req_op1, req_op2, req_ww, req_mode, mul_prod, rsp_ready,
        input  req_ready, sel_op1, sel_op2, sel_odd, sel_ww, mul_issue,
               rsp_valid, rsp_even, rsp_odd, rsp_err, ops_done
    );
endinterface

// File: rtl/oe_tag_pipe.sv
// rtl/oe_tag_pipe.sv - shift pipeline tracking which multiplier result belongs to which pass
module oe_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_odd,
    output logic out_valid,
    output logic out_odd,
    output logic pending
);
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] odd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            odd <= '0;
        end else begin
            vld[0] <= in_valid;
            odd[0] <= in_odd;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                odd[i] <= odd[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_odd   = odd[DEPTH-1];

    // Tags still in flight behind the output stage
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | vld[i];
        end
    end
endmodule

// File: rtl/oe_mul_seq.sv
// rtl/oe_mul_seq.sv - sequences even/odd multiply passes and collects their products
module oe_mul_seq
    import oe_mul_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    oe_mul_seq_if.slave  bus
);
    state_t      state, state_nxt;
    logic [1:0]  mode_q;
    logic        sel_odd, sel_odd_q;
    logic        mul_issue;
    logic        accept;
    logic        rsp_valid;
    logic [63:0] sel_op1, sel_op2, rsp_even, rsp_odd;
    logic [1:0]  sel_ww;
    logic        rsp_err;
    logic [15:0] ops_cnt;
    logic        tag_valid, tag_odd, tag_pending;

    oe_tag_pipe #(.DEPTH(MUL_LAT)) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mul_issue),
        .in_odd    (sel_odd),
        .out_valid (tag_valid),
        .out_odd   (tag_odd),
        .pending   (tag_pending)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        mul_issue     = 1'b0;
        rsp_valid     = 1'b0;
        sel_odd       = sel_odd_q;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (req_illegal(bus.req_mode, bus.req_ww)) begin
                        state_nxt = RESP;
                    end else if (bus.req_mode == MODE_ODD) begin
                        state_nxt = ISSUE_O;
                    end else begin
                        state_nxt = ISSUE_E;
                    end
                end
            end
            ISSUE_E: begin
                mul_issue = 1'b1;
                sel_odd   = 1'b0;
                state_nxt = (mode_q == MODE_BOTH) ? ISSUE_O : DRAIN;
            end
            ISSUE_O: begin
                mul_issue = 1'b1;
                sel_odd   = 1'b1;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                // Last tag sits in the output stage and is consumed on this edge
                if (!tag_pending) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_EVEN;
            sel_odd_q <= 1'b0;
            sel_op1   <= '0;
            sel_op2   <= '0;
            sel_ww    <= WW_BYTE;
            rsp_even  <= '0;
            rsp_odd   <= '0;
            rsp_err   <= 1'b0;
            ops_cnt   <= '0;
        end else begin
            sel_odd_q <= sel_odd;
            if (accept) begin
                mode_q   <= bus.req_mode;
                sel_op1  <= bus.req_op1;
                sel_op2  <= bus.req_op2;
                sel_ww   <= bus.req_ww;
                rsp_even <= '0;
                rsp_odd  <= '0;
                rsp_err  <= req_illegal(bus.req_mode, bus.req_ww);
            end
            if (tag_valid) begin
                if (tag_odd) begin
                    rsp_odd <= bus.mul_prod;
                end else begin
                    rsp_even <= bus.mul_prod;
                end
            end
            if (rsp_valid && bus.rsp_ready) begin
                ops_cnt <= ops_cnt + 16'd1;
            end
        end
    end

    assign bus.sel_op1   = sel_op1;
    assign bus.sel_op2   = sel_op2;
    assign bus.sel_ww    = sel_ww;
    assign bus.sel_odd   = sel_odd;
    assign bus.mul_issue = mul_issue;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_even  = rsp_even;
    assign bus.rsp_odd   = rsp_odd;
    assign bus.rsp_err   = rsp_err;
    assign bus.ops_done  = ops_cnt;
endmodule

// File: tb/tb_oe_mul_seq.sv
// tb/tb_oe_mul_seq.sv - directed self-checking bench for oe_mul_seq
module tb_oe_mul_seq;
    import oe_mul_pkg::*;

    localparam int MUL_LAT = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] exp_ops;

    oe_mul_seq_if bus ();

    oe_mul_seq #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge with the sequencer idle and rsp_ready low
    task automatic do_op(input string tag, input logic [1:0] mode, input logic [1:0] ww,
                         input logic [63:0] op1, input logic [63:0] op2,
                         input logic [63:0] pe, input logic [63:0] po, input int lat,
                         input logic [7:0] exp_iss, input logic [7:0] exp_odd,
                         input logic [63:0] exp_e, input logic [63:0] exp_o,
                         input logic exp_err, input int hold);
        logic [7:0] iss;
        logic [7:0] so;
        iss = '0;
        so  = '0;
        bus.req_op1   = op1;
        bus.req_op2   = op2;
        bus.req_ww    = ww;
        bus.req_mode  = mode;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            iss[k] = bus.mul_issue;
            so[k]  = bus.sel_odd;
            check($sformatf("%s_issue_T%0d", tag, k), 64'(bus.mul_issue), 64'(exp_iss[k]));
            if (exp_iss[k]) check($sformatf("%s_sel_odd_T%0d", tag, k), 64'(bus.sel_odd), 64'(exp_odd[k]));
            if (k > MUL_LAT && iss[k-MUL_LAT]) bus.mul_prod = so[k-MUL_LAT] ? po : pe;
            else bus.mul_prod = 64'hDEAD_0000_0000_0000 | 64'(k);
            check($sformatf("%s_rsp_valid_T%0d", tag, k), 64'(bus.rsp_valid), 64'(k == lat));
            if (k < lat) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.mul_prod = 64'hDEAD_FFFF_0000_0000;
        check({tag, "_even"}, bus.rsp_even, exp_e);
        check({tag, "_odd"}, bus.rsp_odd, exp_o);
        check({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
        check({tag, "_sel_op1"}, bus.sel_op1, op1);
        check({tag, "_sel_op2"}, bus.sel_op2, op2);
        check({tag, "_sel_ww"}, 64'(bus.sel_ww), 64'(ww));
        check({tag, "_busy_ready"}, 64'(bus.req_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1;
            bus.req_op1   = ~op1;
            bus.req_op2   = ~op2;
            bus.req_mode  = MODE_ODD;
            bus.req_ww    = WW_HALF;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_hold%0d_valid", tag, h), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("%s_hold%0d_even", tag, h), bus.rsp_even, exp_e);
            check($sformatf("%s_hold%0d_odd", tag, h), bus.rsp_odd, exp_o);
            check($sformatf("%s_hold%0d_op1", tag, h), bus.sel_op1, op1);
            check($sformatf("%s_hold%0d_ready", tag, h), 64'(bus.req_ready), 64'd0);
            check($sformatf("%s_hold%0d_ops", tag, h), 64'(bus.ops_done), 64'(exp_ops));
            check($sformatf("%s_hold%0d_issue", tag, h), 64'(bus.mul_issue), 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        exp_ops = exp_ops + 16'd1;
        check({tag, "_ops_done"}, 64'(bus.ops_done), 64'(exp_ops));
        check({tag, "_idle_ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, "_idle_valid"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks        = 0;
        errors        = 0;
        exp_ops       = '0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.req_ww    = '0;
        bus.req_mode  = '0;
        bus.mul_prod  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_issue", 64'(bus.mul_issue), 64'd0);
        check("rst_ops", 64'(bus.ops_done), 64'd0);
        check("rst_even", bus.rsp_even, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("even", MODE_EVEN, WW_WORD, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
              64'h1234, 64'h5678, 4, 8'h02, 8'h00, 64'h1234, 64'h0, 1'b0, 0);
        do_op("both", MODE_BOTH, WW_BYTE, 64'h0102_0304_0506_0708, 64'h0A0B_0C0D_0E0F_1011,
              64'hAA, 64'hBB, 5, 8'h06, 8'h04, 64'hAA, 64'hBB, 1'b0, 0);
        do_op("odd", MODE_ODD, WW_HALF, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF,
              64'h77, 64'h99, 4, 8'h02, 8'h02, 64'h0, 64'h99, 1'b0, 0);
        do_op("ill_mode", MODE_ILL, WW_BYTE, 64'hABCD, 64'hEF01,
              64'h1, 64'h2, 1, 8'h00, 8'h00, 64'h0, 64'h0, 1'b1, 0);
        do_op("ill_ww", MODE_EVEN, WW_ILL, 64'h4242, 64'h2424,
              64'h1, 64'h2, 1, 8'h00, 8'h00, 64'h0, 64'h0, 1'b1, 0);
        do_op("bp", MODE_EVEN, WW_WORD, 64'hCAFE_F00D_0000_0001, 64'h3,
              64'hC0FFEE, 64'h1, 4, 8'h02, 8'h00, 64'hC0FFEE, 64'h0, 1'b0, 5);

        // Reset while the odd pass of a both-pass request is still in flight
        bus.req_op1   = 64'h9999;
        bus.req_op2   = 64'h8888;
        bus.req_ww    = WW_BYTE;
        bus.req_mode  = MODE_BOTH;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.mul_prod = 64'hAA;
        @(posedge clk);
        @(negedge clk);
        check("drain_even", bus.rsp_even, 64'hAA);
        bus.mul_prod = 64'hBB;
        reset = 1'b1;
        #1;
        check("rstmid_ready", 64'(bus.req_ready), 64'd1);
        check("rstmid_valid", 64'(bus.rsp_valid), 64'd0);
        check("rstmid_issue", 64'(bus.mul_issue), 64'd0);
        check("rstmid_even", bus.rsp_even, 64'd0);
        check("rstmid_odd", bus.rsp_odd, 64'd0);
        check("rstmid_op1", bus.sel_op1, 64'd0);
        check("rstmid_ww", 64'(bus.sel_ww), 64'd0);
        check("rstmid_sel_odd", 64'(bus.sel_odd), 64'd0);
        check("rstmid_ops", 64'(bus.ops_done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_ops = '0;
        do_op("post_rst", MODE_EVEN, WW_HALF, 64'h7, 64'h8,
              64'h4321, 64'h8765, 4, 8'h02, 8'h00, 64'h4321, 64'h0, 1'b0, 0);

        // Counter wrap from 0xFFFF
        force dut.ops_cnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.ops_cnt;
        @(posedge clk);
        @(negedge clk);
        check("wrap_preload", 64'(bus.ops_done), 64'hFFFF);
        exp_ops = 16'hFFFF;
        do_op("wrap", MODE_ILL, WW_ILL, 64'h1, 64'h2,
              64'h0, 64'h0, 1, 8'h00, 8'h00, 64'h0, 64'h0, 1'b1, 0);
        check("wrap_zero", 64'(bus.ops_done), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
